decode: RTL

- Decode stage of the 5-stage RV32I pipeline, directly downstream of fetch.
- Contains the IF/ID pipeline register, the 32x32 integer register file, the main control decoder, the immediate generator and the ID/EX pipeline register.
- Consumes fetch outputs (instruction, PC, PC+4, prediction bit) and feeds execute.
- Honours stall and flush from the hazard unit.

---
 rtl/decode.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/decode.sv
// RV32I decode stage: IF/ID register, 32x32 register file, control decoder,
// immediate generator and ID/EX register.
module decode #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          NUM_REGS  = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_D,
  input  logic        Flush_D,
  input  logic        Flush_E,
  input  logic [31:0] Instr_F,
  input  logic [31:0] PC_F,
  input  logic [31:0] PC_Plus_4_F,
  input  logic        Predict_Taken_F,
  input  logic        Reg_Write_W,
  input  logic [4:0]  Rd_W,
  input  logic [31:0] Result_W,
  output logic [4:0]  Rs1_D,
  output logic [4:0]  Rs2_D,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  Rs1_E,
  output logic [4:0]  Rs2_E,
  output logic [4:0]  Rd_E,
  output logic [31:0] PC_E,
  output logic [31:0] PC_Plus_4_E,
  output logic        Predict_Taken_E,
  output logic        Reg_Write_E,
  output logic        Mem_Write_E,
  output logic        Mem_Read_E,
  output logic        Branch_E,
  output logic        Jump_E,
  output logic        ALU_Src_A_E,
  output logic        ALU_Src_B_E,
  output logic [3:0]  ALU_Op_E,
  output logic [1:0]  Result_Src_E,
  output logic [2:0]  Funct3_E,
  output logic        Illegal_E
);

  // RV32I always has 32 architectural registers; larger values are tolerated.
  localparam int RF_DEPTH = (NUM_REGS > 32) ? NUM_REGS : 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  logic [31:0] instr_d, pc_d, pc4_d;
  logic        pred_d;
  logic [31:0] rf [RF_DEPTH];

  always_ff @(posedge CLK) begin
    if (RST || Flush_D) begin
      instr_d <= NOP_INSTR;
      pc_d    <= '0;
      pc4_d   <= '0;
      pred_d  <= 1'b0;
    end else if (!Stall_D) begin
      instr_d <= Instr_F;
      pc_d    <= PC_F;
      pc4_d   <= PC_Plus_4_F;
      pred_d  <= Predict_Taken_F;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (Reg_Write_W && Rd_W != 5'd0) begin
      rf[Rd_W] <= Result_W;
    end
  end

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7b5;
  logic [4:0]  rd_d;
  logic [31:0] rd1_d, rd2_d;

  assign opcode = instr_d[6:0];
  assign funct3 = instr_d[14:12];
  assign f7b5   = instr_d[30];
  assign rd_d   = instr_d[11:7];
  assign Rs1_D  = instr_d[19:15];
  assign Rs2_D  = instr_d[24:20];

  // Write-through so an instruction reading a register in its writeback cycle sees the new value.
  always_comb begin
    rd1_d = rf[Rs1_D];
    rd2_d = rf[Rs2_D];
    if (Rs1_D == 5'd0) rd1_d = '0;
    else if (Reg_Write_W && Rd_W == Rs1_D) rd1_d = Result_W;
    if (Rs2_D == 5'd0) rd2_d = '0;
    else if (Reg_Write_W && Rd_W == Rs2_D) rd2_d = Result_W;
  end

  logic       reg_write, mem_write, mem_read, branch, jump, src_a, src_b, illegal;
  logic [3:0] alu_op;
  logic [1:0] result_src;
  logic [31:0] imm;
  logic [3:0] alu_fn;

  // Only R-type uses funct7[5] to pick SUB; both R and I shifts use it for SRA.
  always_comb begin
    alu_fn = ALU_ADD;
    case (funct3)
      3'b000:  alu_fn = (opcode == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  end

  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    src_a      = 1'b0;
    src_b      = 1'b0;
    illegal    = 1'b0;
    alu_op     = ALU_ADD;
    result_src = 2'b00;
    imm        = '0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = alu_fn;
      end
      OP_I_ALU: begin
        reg_write = 1'b1;
        src_b     = 1'b1;
        alu_op    = alu_fn;
        imm       = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_LOAD: begin
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        src_b      = 1'b1;
        result_src = 2'b01;
        imm        = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_STORE: begin
        mem_write = 1'b1;
        src_b     = 1'b1;
        imm       = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
      end
      OP_BRANCH: begin
        branch = 1'b1;
        alu_op = ALU_SUB;
        imm    = {{20{instr_d[31]}}, instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
      end
      OP_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        result_src = 2'b10;
        imm        = {{12{instr_d[31]}}, instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};
      end
      OP_JALR: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        src_b      = 1'b1;
        result_src = 2'b10;
        imm        = {{20{instr_d[31]}}, instr_d[31:20]};
      end
      OP_LUI: begin
        reg_write = 1'b1;
        src_b     = 1'b1;
        alu_op    = ALU_PASS_B;
        imm       = {instr_d[31:12], 12'b0};
      end
      OP_AUIPC: begin
        reg_write = 1'b1;
        src_a     = 1'b1;
        src_b     = 1'b1;
        imm       = {instr_d[31:12], 12'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || Flush_E) begin
      RD1_E           <= '0;
      RD2_E           <= '0;
      Imm_Ext_E       <= '0;
      Rs1_E           <= '0;
      Rs2_E           <= '0;
      Rd_E            <= '0;
      PC_E            <= '0;
      PC_Plus_4_E     <= '0;
      Predict_Taken_E <= 1'b0;
      Reg_Write_E     <= 1'b0;
      Mem_Write_E     <= 1'b0;
      Mem_Read_E      <= 1'b0;
      Branch_E        <= 1'b0;
      Jump_E          <= 1'b0;
      ALU_Src_A_E     <= 1'b0;
      ALU_Src_B_E     <= 1'b0;
      ALU_Op_E        <= '0;
      Result_Src_E    <= '0;
      Funct3_E        <= '0;
      Illegal_E       <= 1'b0;
    end else begin
      RD1_E           <= rd1_d;
      RD2_E           <= rd2_d;
      Imm_Ext_E       <= imm;
      Rs1_E           <= Rs1_D;
      Rs2_E           <= Rs2_D;
      Rd_E            <= rd_d;
      PC_E            <= pc_d;
      PC_Plus_4_E     <= pc4_d;
      Predict_Taken_E <= pred_d;
      Reg_Write_E     <= reg_write;
      Mem_Write_E     <= mem_write;
      Mem_Read_E      <= mem_read;
      Branch_E        <= branch;
      Jump_E          <= jump;
      ALU_Src_A_E     <= src_a;
      ALU_Src_B_E     <= src_b;
      ALU_Op_E        <= alu_op;
      Result_Src_E    <= result_src;
      Funct3_E        <= funct3;
      Illegal_E       <= illegal;
    end
  end

endmodule
